hgw_sat_sched: RTL and testbench

//  Round-robin scheduler sharing one unsigned saturation stage (I_W -> O_W) among N_REQ requesters.

---
 rtl/hgw_sat_pkg.sv | 13 +
 rtl/hgw_sat_sched_if.sv | 23 ++
 rtl/hgw_rr_arb.sv | 34 +++
 rtl/hgw_sat_unsigned.sv | 15 +
 rtl/hgw_sat_sched.sv | 75 +++++++
 tb/tb_hgw_sat_sched.sv | 151 +++++++++++++++
 6 files changed

// File: rtl/hgw_sat_pkg.sv
// hgw_sat_pkg: shared default widths and clog2 helper for the saturation scheduler family
package hgw_sat_pkg;
   localparam int HGW_SAT_I_W = 16;
   localparam int HGW_SAT_O_W = 15;
   localparam int HGW_SAT_N_REQ = 4;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
   localparam int HGW_SAT_ID_W = clog2(HGW_SAT_N_REQ);
endpackage

// File: rtl/hgw_sat_sched_if.sv
// hgw_sat_sched_if: requester and output handshake bundle of hgw_sat_sched
//   req_vld/req_dat/req_rdy : per-requester valid, flattened samples, one-hot accept
//   o_vld/o_rdy/o_dat/o_id/o_sat : registered output sample, ready, id, clamp flag
//   slave = scheduler side, master = requester/consumer side
interface hgw_sat_sched_if
   import hgw_sat_pkg::*;
#(
   parameter int N_REQ = HGW_SAT_N_REQ,
   parameter int I_W = HGW_SAT_I_W,
   parameter int O_W = HGW_SAT_O_W,
   parameter int ID_W = clog2(N_REQ)
);
   logic [N_REQ-1:0] req_vld;
   logic [N_REQ*I_W-1:0] req_dat;
   logic [N_REQ-1:0] req_rdy;
   logic o_vld;
   logic o_rdy;
   logic [O_W-1:0] o_dat;
   logic [ID_W-1:0] o_id;
   logic o_sat;
   modport slave (input req_vld, req_dat, o_rdy, output req_rdy, o_vld, o_dat, o_id, o_sat);
   modport master (output req_vld, req_dat, o_rdy, input req_rdy, o_vld, o_dat, o_id, o_sat);
endinterface

// File: rtl/hgw_rr_arb.sv
// hgw_rr_arb: combinational round-robin arbiter, first request at or above ptr with wrap
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot grant, idx : encoded grant, any : some request present
module hgw_rr_arb
   import hgw_sat_pkg::*;
#(
   parameter int N_REQ = HGW_SAT_N_REQ,
   parameter int ID_W = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);
   logic found;
   int j;
   always_comb begin
      gnt = '0;
      idx = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            gnt[j] = 1'b1;
            idx = ID_W'(j);
         end
      end
   end
   assign any = |req;
endmodule

// File: rtl/hgw_sat_unsigned.sv
// hgw_sat_unsigned: clamps an unsigned I_W-bit value to O_W bits
//   in : input sample, out : clamped sample, sat : 1 when clamping occurred
module hgw_sat_unsigned
   import hgw_sat_pkg::*;
#(
   parameter int I_W = HGW_SAT_I_W,
   parameter int O_W = HGW_SAT_O_W
) (
   input  logic [I_W-1:0] in,
   output logic [O_W-1:0] out,
   output logic           sat
);
   assign sat = |in[I_W-1:O_W];
   assign out = in[O_W-1:0] | {O_W{sat}};
endmodule

// File: rtl/hgw_sat_sched.sv
// hgw_sat_sched: round-robin scheduler sharing one unsigned saturation stage among N_REQ requesters
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hgw_sat_sched_if.slave (requester handshakes, registered output sample)
//   cnt_clr    : synchronous clear of sat_cnt
//   sat_cnt    : saturating count of clamped transfers
//   HGW_SAT_SCHED_CNT_EN enables the counter; otherwise sat_cnt is 0 and cnt_clr is ignored
module hgw_sat_sched
   import hgw_sat_pkg::*;
#(
   parameter int N_REQ = HGW_SAT_N_REQ,
   parameter int I_W = HGW_SAT_I_W,
   parameter int O_W = HGW_SAT_O_W,
   parameter int ID_W = clog2(N_REQ),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   hgw_sat_sched_if.slave   bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] sat_cnt
);
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0] idx, ptr;
   logic any, acc, xfer, sat, vld_q, sat_q;
   logic [I_W-1:0] sel_dat;
   logic [O_W-1:0] sat_dat, dat_q;
   logic [ID_W-1:0] id_q;
`ifdef RTL_SIM
   initial if (I_W <= O_W || N_REQ < 2) begin
      $display("hgw_sat_sched: illegal parameters I_W=%0d O_W=%0d N_REQ=%0d", I_W, O_W, N_REQ);
      $finish;
   end
`endif
   hgw_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req(bus.req_vld), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any)
   );
   // rst_n gates the accept so no requester sees ready while the stage is held in reset
   assign acc = rst_n & (~vld_q | bus.o_rdy);
   assign xfer = any & acc;
   assign bus.req_rdy = gnt & {N_REQ{acc}};
   assign sel_dat = bus.req_dat[idx*I_W +: I_W];
   hgw_sat_unsigned #(.I_W(I_W), .O_W(O_W)) u_sat (.in(sel_dat), .out(sat_dat), .sat(sat));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         id_q <= '0;
         sat_q <= 1'b0;
         ptr <= '0;
      end else if (xfer) begin
         vld_q <= 1'b1;
         dat_q <= sat_dat;
         id_q <= idx;
         sat_q <= sat;
         ptr <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end else if (bus.o_rdy) begin
         vld_q <= 1'b0;
      end
   end
   assign bus.o_vld = vld_q;
   assign bus.o_dat = dat_q;
   assign bus.o_id = id_q;
   assign bus.o_sat = sat_q;
`ifdef HGW_SAT_SCHED_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_cnt <= '0;
      else if (cnt_clr) sat_cnt <= '0;
      else if (xfer && sat && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_hgw_sat_sched.sv
// tb_hgw_sat_sched: randomized self-checking bench for hgw_sat_sched against a behavioural model
module tb_hgw_sat_sched;
   localparam int N = 4, IW = 16, OW = 15, IDW = 2;
   localparam int OMAX = (1 << OW) - 1;
`ifdef HGW_SAT_SCHED_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif
   logic clk = 1'b0, rst_n = 1'b0, cnt_clr = 1'b0;
   logic [CW-1:0] sat_cnt;
   int n_chk = 0, n_pass = 0;
   int m_vld, m_dat, m_id, m_sat, m_ptr;
   longint m_cnt;
   always #5 clk = ~clk;
   hgw_sat_sched_if #(.N_REQ(N), .I_W(IW), .O_W(OW), .ID_W(IDW)) bus ();
   hgw_sat_sched #(.N_REQ(N), .I_W(IW), .O_W(OW), .ID_W(IDW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   function automatic int grant();
      for (int k = 0; k < N; k++)
         if (bus.req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction
   task automatic set_dat(input int k, input int v);
      bus.req_dat[k*IW +: IW] = IW'(v);
   endtask
   task automatic cyc();
      int g, v, s;
      bit acc, xfer;
      #1;
      g = grant();
      acc = (m_vld == 0) || bus.o_rdy;
      xfer = (g >= 0) && acc;
      chk("req_rdy", 64'(bus.req_rdy), xfer ? 64'(1 << g) : 64'd0);
      chk("o_vld", 64'(bus.o_vld), 64'(m_vld));
      if (m_vld != 0) begin
         chk("o_dat", 64'(bus.o_dat), 64'(m_dat));
         chk("o_id", 64'(bus.o_id), 64'(m_id));
         chk("o_sat", 64'(bus.o_sat), 64'(m_sat));
      end
      chk("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
      v = xfer ? int'(bus.req_dat[g*IW +: IW]) : 0;
      s = (v > OMAX) ? 1 : 0;
      @(posedge clk);
`ifdef HGW_SAT_SCHED_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (xfer && s == 1 && m_cnt < (64'd1 << CW) - 1) m_cnt++;
`endif
      if (xfer) begin
         m_vld = 1;
         m_id = g;
         m_sat = s;
         m_dat = (s == 1) ? OMAX : v;
         m_ptr = (g + 1) % N;
      end else if (bus.o_rdy) m_vld = 0;
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
      chk("rst_o_vld", 64'(bus.o_vld), 64'd0);
      chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
      chk("rst_o_dat", 64'(bus.o_dat), 64'd0);
      m_vld = 0; m_dat = 0; m_id = 0; m_sat = 0; m_ptr = 0; m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      bus.req_vld = '0;
      bus.req_dat = '0;
      bus.o_rdy = 1'b1;
      @(negedge clk);
      bus.req_vld = 4'hF;
      do_reset();
      for (int k = 0; k < N; k++) set_dat(k, 16'h0100 * (k + 1));
      #1 chk("first_grant", 64'(bus.req_rdy), 64'd1);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_seq", 64'(bus.o_id), 64'(i % 4));
      end
      bus.req_vld = 4'b0100;
      set_dat(2, 16'h8001);
      cyc();
      chk("sat_dat", 64'(bus.o_dat), 64'h7FFF);
      chk("sat_flag", 64'(bus.o_sat), 64'd1);
      bus.req_vld = 4'b0010;
      set_dat(1, 16'h1234);
      cyc();
      chk("pass_dat", 64'(bus.o_dat), 64'h1234);
      chk("pass_flag", 64'(bus.o_sat), 64'd0);
      bus.req_vld = 4'hF;
      cyc();
      bus.o_rdy = 1'b0;
      repeat (5) cyc();
      chk("bp_hold_id", 64'(bus.o_id), 64'd2);
      bus.o_rdy = 1'b1;
      cyc();
      chk("bp_next_ptr", 64'(bus.o_id), 64'd3);
      bus.req_vld = 4'b0100;
      cyc();
      bus.req_vld = 4'b0010;
      cyc();
      chk("skip_wrap", 64'(bus.o_id), 64'd1);
      bus.req_vld = 4'hF;
      cyc();
      chk("ptr_after_wrap", 64'(bus.o_id), 64'd2);
      for (int k = 0; k < N; k++) set_dat(k, 16'hFFFF);
      repeat (20) cyc();
`ifdef HGW_SAT_SCHED_CNT_EN
      chk("cnt_stick", 64'(sat_cnt), 64'hF);
`else
      chk("cnt_off", 64'(sat_cnt), 64'd0);
`endif
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      chk("cnt_clr_wins", 64'(sat_cnt), 64'd0);
      repeat (400) begin
         bus.req_vld = N'($urandom);
         for (int k = 0; k < N; k++)
            set_dat(k, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 16'h7FFF) : $urandom_range(16'h8000, 16'hFFFF));
         bus.o_rdy = ($urandom_range(0, 3) != 0);
         cnt_clr = ($urandom_range(0, 31) == 0);
         cyc();
      end
      cnt_clr = 1'b0;
      bus.req_vld = 4'hF;
      bus.o_rdy = 1'b0;
      cyc();
      chk("pre_reset_vld", 64'(bus.o_vld), 64'd1);
      do_reset();
      bus.o_rdy = 1'b1;
      cyc();
      chk("post_reset_grant", 64'(bus.o_id), 64'd0);
      repeat (50) begin
         bus.req_vld = N'($urandom);
         for (int k = 0; k < N; k++) set_dat(k, $urandom_range(0, 16'hFFFF));
         bus.o_rdy = $urandom_range(0, 1);
         cyc();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
